opb_register_simulink2ppc: RTL

- Read-back counterpart of the PPC-to-fabric software register: fabric logic writes a 32-bit value and the PowerPC reads it over the OPB slave bus.
- Adds a capture counter and a freeze control bit so software can take coherent snapshots.
- One instance per design-exported status register, instantiated from a per-register wrapper on the OPB bus.
- Single clock domain: the user side is synchronous to OPB_Clk.

---
 rtl/opb_sw_reg_pkg.sv | 26 ++
 rtl/opb_slave_ack_fsm.sv | 79 +++++++
 rtl/opb_register_simulink2ppc.sv | 108 ++++++++++
 3 files changed

// File: rtl/opb_sw_reg_pkg.sv
// Shared definitions for OPB software-register slaves: register offsets,
// slave handshake states and the word-offset helper used by address decode.
package opb_sw_reg_pkg;

    localparam logic [7:0] REG_DATA  = 8'h00;
    localparam logic [7:0] REG_COUNT = 8'h04;
    localparam logic [7:0] REG_CTRL  = 8'h08;

    // Freeze lives in the least significant user bit, which OPB numbers 31.
    localparam int CTRL_FREEZE_BIT = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        GAP  = 2'd2
    } slave_state_t;

    // Word-aligned byte offset of an address inside a 256-byte window.
    function automatic logic [7:0] word_offset(input logic [31:0] addr,
                                               input logic [31:0] base);
        logic [7:0] low;
        low = 8'(addr - base);
        return low & 8'hFC;
    endfunction

endpackage

// File: rtl/opb_slave_ack_fsm.sv
// Generic OPB slave handshake: window decode, IDLE/ACK/GAP sequencing,
// latched request fields and read-data gating. The owning block supplies a
// read mux addressed by hit_offset and acts on the latched write fields.
module opb_slave_ack_fsm
    import opb_sw_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01008100,
    parameter logic [31:0] C_HIGHADDR   = 32'h010081FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [0:C_OPB_AWIDTH-1] abus,
    input  logic [0:3]              be,
    input  logic [0:C_OPB_DWIDTH-1] dbus,
    input  logic                    rnw,
    input  logic                    select,
    input  logic [C_OPB_DWIDTH-1:0] rd_data,
    output logic [7:0]              hit_offset,
    output logic [7:0]              req_offset_reg,
    output logic                    req_rnw_reg,
    output logic [0:C_OPB_DWIDTH-1] req_dbus_reg,
    output logic [0:3]              req_be_reg,
    output logic                    ack_cycle,
    output logic [0:C_OPB_DWIDTH-1] sl_dbus
);

    slave_state_t              state_reg;
    slave_state_t              state_next;
    logic [31:0]               addr;
    logic                      hit;
    logic [0:C_OPB_DWIDTH-1]   rd_reg;

    assign addr       = 32'(abus);
    assign hit        = select && (addr >= C_BASEADDR) && (addr <= C_HIGHADDR);
    assign hit_offset = word_offset(addr, C_BASEADDR);

    // State register; reset clears it at once so the ack drops without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state: decode only in IDLE, so a select held through GAP is not re-acked.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (hit) state_next = ACK;
            ACK:     state_next = GAP;
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture request fields and the read snapshot on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_offset_reg <= '0;
            req_rnw_reg    <= 1'b0;
            req_dbus_reg   <= '0;
            req_be_reg     <= '0;
            rd_reg         <= '0;
        end else if (state_reg == IDLE && hit) begin
            req_offset_reg <= hit_offset;
            req_rnw_reg    <= rnw;
            req_dbus_reg   <= dbus;
            req_be_reg     <= be;
            rd_reg         <= rd_data;
        end
    end

    assign ack_cycle = (state_reg == ACK);
    assign sl_dbus   = (ack_cycle && req_rnw_reg) ? rd_reg : '0;

endmodule

// File: rtl/opb_register_simulink2ppc.sv
// Fabric-to-PowerPC status register: holds the last captured fabric value,
// a capture counter and a software freeze bit, exposed over an OPB slave.
module opb_register_simulink2ppc
    import opb_sw_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR   = 32'h01008100,
    parameter logic [31:0] C_HIGHADDR   = 32'h010081FF,
    parameter int          C_OPB_AWIDTH = 32,
    parameter int          C_OPB_DWIDTH = 32,
    parameter string       C_FAMILY     = "virtex5"
) (
    input  logic                    OPB_Clk,
    input  logic                    OPB_Rst_n,
    input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
    input  logic [0:3]              OPB_BE,
    input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
    input  logic                    OPB_RNW,
    input  logic                    OPB_select,
    input  logic                    OPB_seqAddr,
    output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
    output logic                    Sl_errAck,
    output logic                    Sl_retry,
    output logic                    Sl_toutSup,
    output logic                    Sl_xferAck,
    input  logic [31:0]             user_data_in,
    input  logic                    user_data_valid,
    output logic                    user_frozen
);

    logic [31:0]               data_reg;
    logic [31:0]               count_reg;
    logic                      freeze_reg;
    logic [31:0]               rd_mux;
    logic [7:0]                hit_offset;
    logic [7:0]                req_offset_reg;
    logic                      req_rnw_reg;
    logic [0:C_OPB_DWIDTH-1]   req_dbus_reg;
    logic [0:3]                req_be_reg;
    logic                      ack_cycle;
    logic                      capture;
    logic                      ctrl_write;
    logic                      unused_ok;

    opb_slave_ack_fsm #(
        .C_BASEADDR   (C_BASEADDR),
        .C_HIGHADDR   (C_HIGHADDR),
        .C_OPB_AWIDTH (C_OPB_AWIDTH),
        .C_OPB_DWIDTH (C_OPB_DWIDTH)
    ) u_fsm (
        .clk            (OPB_Clk),
        .rst_n          (OPB_Rst_n),
        .abus           (OPB_ABus),
        .be             (OPB_BE),
        .dbus           (OPB_DBus),
        .rnw            (OPB_RNW),
        .select         (OPB_select),
        .rd_data        (rd_mux),
        .hit_offset     (hit_offset),
        .req_offset_reg (req_offset_reg),
        .req_rnw_reg    (req_rnw_reg),
        .req_dbus_reg   (req_dbus_reg),
        .req_be_reg     (req_be_reg),
        .ack_cycle      (ack_cycle),
        .sl_dbus        (Sl_DBus)
    );

    // Read mux keyed on the live offset so the snapshot taken at accept is coherent.
    always_comb begin
        rd_mux = '0;
        case (hit_offset)
            REG_DATA:  rd_mux = data_reg;
            REG_COUNT: rd_mux = count_reg;
            REG_CTRL:  rd_mux[0] = freeze_reg;
            default:   rd_mux = '0;
        endcase
    end

    assign capture    = user_data_valid && !freeze_reg;
    assign ctrl_write = ack_cycle && !req_rnw_reg && (req_offset_reg == REG_CTRL)
                        && req_be_reg[3];

    // Capture path and freeze update; a capture on the freeze edge sees the old freeze.
    always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
            data_reg   <= '0;
            count_reg  <= '0;
            freeze_reg <= 1'b0;
        end else begin
            if (capture) begin
                data_reg  <= user_data_in;
                count_reg <= count_reg + 32'd1;
            end
            if (ctrl_write) begin
                freeze_reg <= req_dbus_reg[CTRL_FREEZE_BIT];
            end
        end
    end

    assign Sl_xferAck  = ack_cycle;
    assign Sl_errAck   = 1'b0;
    assign Sl_retry    = 1'b0;
    assign Sl_toutSup  = 1'b0;
    assign user_frozen = freeze_reg;

    // Sequential-address hint and the non-freeze write bits carry no meaning here.
    assign unused_ok = ^{OPB_seqAddr, req_dbus_reg[0:CTRL_FREEZE_BIT-1], req_be_reg[0:2]};

endmodule
